// File: rtl/alarm_pkg.sv
// Shared types and parameter defaults for the alarm siren controller.
// Every block of the alarm path imports this package.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_SOUND   = 2'd2,
    ST_HOLDOFF = 2'd3
  } alarm_state_e;

  localparam int DEF_DEBOUNCE_CYC  = 4;
  localparam int DEF_BEEP_ON_CYC   = 8;
  localparam int DEF_BEEP_OFF_CYC  = 8;
  localparam int DEF_TIMEOUT_BEEPS = 16;
  localparam int DEF_HOLDOFF_CYC   = 32;

  localparam logic [3:0] EVENT_CNT_MAX = 4'd15;

endpackage

// File: rtl/alarm_debounce.sv
// Counts consecutive high samples of the raw alarm and flags the sample that
// completes the qualification window; clear holds the count at zero.
module alarm_debounce
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sAlarm,
  input  logic clear,
  output logic qual
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The qualifying sample is the one that would make the count DEBOUNCE_CYC,
  // so the FSM can enter SOUND on the same edge.
  assign qual = sAlarm && !clear && (cnt_q == CW'(DEBOUNCE_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !sAlarm || qual) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_siren.sv
// Alarm siren controller: debounced trigger, beep pattern with timeout,
// acknowledge-driven mute with a minimum holdoff and re-arm on alarm release.
module alarm_siren
  import alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int BEEP_ON_CYC   = DEF_BEEP_ON_CYC,
  parameter int BEEP_OFF_CYC  = DEF_BEEP_OFF_CYC,
  parameter int TIMEOUT_BEEPS = DEF_TIMEOUT_BEEPS,
  parameter int HOLDOFF_CYC   = DEF_HOLDOFF_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sAlarm,
  input  logic       sAck,
  output logic       sSiren,
  output logic       sMuted,
  output logic [3:0] sEventCnt,
  output logic [1:0] dbg_state
);

  localparam int PH_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int BEEP_W = $clog2(TIMEOUT_BEEPS) + 1;
  localparam int HO_W   = $clog2(HOLDOFF_CYC) + 1;

  alarm_state_e      state_q,     state_d;
  logic              phase_on_q,  phase_on_d;
  logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [BEEP_W-1:0] beep_cnt_q,  beep_cnt_d;
  logic [HO_W-1:0]   ho_cnt_q,    ho_cnt_d;
  logic              siren_q,     siren_d;
  logic              muted_q,     muted_d;
  logic [3:0]        event_cnt_q, event_cnt_d;

  logic qual;
  logic deb_clear;
  logic on_end;
  logic off_end;

  assign deb_clear = (state_q == ST_SOUND) || (state_q == ST_HOLDOFF);

  alarm_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .sAlarm (sAlarm),
    .clear  (deb_clear),
    .qual   (qual)
  );

  assign on_end  = phase_on_q  && (phase_cnt_q == PH_W'(BEEP_ON_CYC - 1));
  assign off_end = !phase_on_q && (phase_cnt_q == PH_W'(BEEP_OFF_CYC - 1));

  always_comb begin
    state_d     = state_q;
    phase_on_d  = phase_on_q;
    phase_cnt_d = phase_cnt_q;
    beep_cnt_d  = beep_cnt_q;
    ho_cnt_d    = ho_cnt_q;
    siren_d     = siren_q;
    muted_d     = muted_q;
    event_cnt_d = event_cnt_q;

    case (state_q)
      ST_IDLE, ST_QUAL: begin
        siren_d = 1'b0;
        muted_d = 1'b0;
        if (qual) begin
          state_d     = ST_SOUND;
          siren_d     = 1'b1;
          phase_on_d  = 1'b1;
          phase_cnt_d = '0;
          beep_cnt_d  = '0;
          if (event_cnt_q != EVENT_CNT_MAX) event_cnt_d = event_cnt_q + 4'd1;
        end else if (sAlarm) begin
          state_d = ST_QUAL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SOUND: begin
        // Ack beats timeout beats alarm release; all three silence the siren at once.
        if (sAck || (on_end && (beep_cnt_q == BEEP_W'(TIMEOUT_BEEPS - 1)))) begin
          state_d     = ST_HOLDOFF;
          siren_d     = 1'b0;
          muted_d     = 1'b1;
          ho_cnt_d    = HO_W'(1);
          phase_on_d  = 1'b0;
          phase_cnt_d = '0;
          beep_cnt_d  = '0;
        end else if (!sAlarm) begin
          state_d     = ST_IDLE;
          siren_d     = 1'b0;
          phase_on_d  = 1'b0;
          phase_cnt_d = '0;
          beep_cnt_d  = '0;
        end else if (on_end) begin
          beep_cnt_d  = beep_cnt_q + 1'b1;
          phase_on_d  = 1'b0;
          phase_cnt_d = '0;
          siren_d     = 1'b0;
        end else if (off_end) begin
          phase_on_d  = 1'b1;
          phase_cnt_d = '0;
          siren_d     = 1'b1;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end

      ST_HOLDOFF: begin
        siren_d = 1'b0;
        // ho_cnt counts muted cycles including the entry cycle and saturates at expiry.
        if (ho_cnt_q == HO_W'(HOLDOFF_CYC)) begin
          if (!sAlarm) begin
            state_d  = ST_IDLE;
            muted_d  = 1'b0;
            ho_cnt_d = '0;
          end
        end else begin
          ho_cnt_d = ho_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        siren_d = 1'b0;
        muted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_on_q  <= 1'b0;
      phase_cnt_q <= '0;
      beep_cnt_q  <= '0;
      ho_cnt_q    <= '0;
      siren_q     <= 1'b0;
      muted_q     <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_on_q  <= phase_on_d;
      phase_cnt_q <= phase_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
      ho_cnt_q    <= ho_cnt_d;
      siren_q     <= siren_d;
      muted_q     <= muted_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign sSiren    = siren_q;
  assign sMuted    = muted_q;
  assign sEventCnt = event_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alarm_siren.sv
// Bench for alarm_siren: directed timing scenarios plus randomized alarm/ack
// traffic, every cycle checked against a timeline model of the siren behaviour.
module tb_alarm_siren;

  localparam int DEB = 4;
  localparam int ON  = 8;
  localparam int OFF = 8;
  localparam int TO  = 16;
  localparam int HO  = 32;
  localparam int PER = ON + OFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sAlarm = 1'b0;
  logic       sAck = 1'b0;
  logic       sSiren;
  logic       sMuted;
  logic [3:0] sEventCnt;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int out_cyc = 0;

  // Expected {siren, muted, event count} per cycle, pushed at the edge, popped at the check.
  logic [5:0] exp_q[$];

  // Model: alarm timeline in terms of elapsed cycles, not FSM states.
  int  run_len;
  bit  sounding;
  int  t_sound;
  bit  muting;
  int  t_mute;
  int  ev;

  alarm_siren #(
    .DEBOUNCE_CYC (DEB),
    .BEEP_ON_CYC  (ON),
    .BEEP_OFF_CYC (OFF),
    .TIMEOUT_BEEPS(TO),
    .HOLDOFF_CYC  (HO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sAlarm    (sAlarm),
    .sAck      (sAck),
    .sSiren    (sSiren),
    .sMuted    (sMuted),
    .sEventCnt (sEventCnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, out_cyc, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    run_len  = 0;
    sounding = 0;
    t_sound  = 0;
    muting   = 0;
    t_mute   = 0;
    ev       = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit a, input bit k);
    logic exp_siren;
    if (sounding) begin
      // Last ON cycle of the final beep sits at (TO-1)*PER + ON-1 cycles into the sound.
      if (k || (t_sound == (TO - 1) * PER + ON - 1)) begin
        sounding = 0;
        muting   = 1;
        t_mute   = 1;
      end else if (!a) begin
        sounding = 0;
      end else begin
        t_sound++;
      end
    end else if (muting) begin
      if (t_mute >= HO) begin
        if (!a) muting = 0;
      end else begin
        t_mute++;
      end
    end else begin
      if (a) begin
        run_len++;
        if (run_len == DEB) begin
          sounding = 1;
          t_sound  = 0;
          run_len  = 0;
          if (ev < 15) ev++;
        end
      end else begin
        run_len = 0;
      end
    end
    exp_siren = sounding && ((t_sound % PER) < ON);
    exp_q.push_back({exp_siren, muting, 4'(ev)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit a, input bit k);
    logic [5:0] e;
    sAlarm = a;
    sAck   = k;
    @(posedge clk);
    model_step(a, k);
    @(negedge clk);
    out_cyc++;
    e = exp_q.pop_front();
    check_eq("model_siren", sSiren, e[5]);
    check_eq("model_muted", sMuted, e[4]);
    check_eq("model_evcnt", sEventCnt, e[3:0]);
  endtask

  task automatic do_reset();
    sAlarm = 1'b0;
    sAck   = 1'b0;
    rst_n  = 1'b0;
    #2;
    check_eq("rst_siren", sSiren, 0);
    check_eq("rst_muted", sMuted, 0);
    check_eq("rst_evcnt", sEventCnt, 0);
    check_eq("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_cyc = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    // Three high samples never qualify.
    for (int i = 0; i < 12; i++) cycle(i < 3, 1'b0);
    check_eq("short_pulse_evcnt", sEventCnt, 0);

    // Held alarm: beep pattern from cycle DEB, then timeout into holdoff.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b0);
      if (out_cyc <= 40)
        check_eq("held_pattern", sSiren, (out_cyc >= 4) && (((out_cyc - 4) % 16) < 8));
      if (out_cyc == 251) check_eq("timeout_last_on", sSiren, 1);
      if (out_cyc == 252) begin
        check_eq("timeout_siren_off", sSiren, 0);
        check_eq("timeout_muted", sMuted, 1);
      end
      if (out_cyc == 283 || out_cyc == 300) check_eq("holdoff_held", sMuted, 1);
    end
    check_eq("held_evcnt", sEventCnt, 1);
    cycle(1'b0, 1'b0);
    check_eq("rearm_unmuted", sMuted, 0);

    // Ack in the same cycle the alarm drops.
    do_reset();
    for (int i = 0; i < 46; i++) begin
      cycle(i < 6, i == 6);
      if (out_cyc >= 7) check_eq("ack_siren", sSiren, 0);
      check_eq("ack_muted", sMuted, (out_cyc >= 7) && (out_cyc <= 38));
      if (out_cyc == 39) check_eq("ack_idle", dbg_state, 0);
    end

    // Asynchronous reset in the middle of an ON phase.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    check_eq("pre_rst_siren", sSiren, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_siren", sSiren, 0);
    check_eq("async_rst_muted", sMuted, 0);
    check_eq("async_rst_evcnt", sEventCnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_cyc = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

    // Seventeen separate triggers saturate the event count.
    do_reset();
    for (int t = 1; t <= 17; t++) begin
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 34; i++) cycle(1'b0, 1'b0);
      check_eq("trigger_evcnt", sEventCnt, (t > 15) ? 15 : t);
    end

    // Randomized alarm runs with sparse acks and occasional resets.
    do_reset();
    begin
      bit lvl;
      int run;
      lvl = 1'b0;
      run = 0;
      for (int i = 0; i < 6000; i++) begin
        if (run == 0) begin
          lvl = ~lvl;
          run = lvl ? $urandom_range(1, 60) : $urandom_range(1, 45);
          if ($urandom_range(0, 9) == 0) run = $urandom_range(250, 320);
        end
        run--;
        if ($urandom_range(0, 1499) == 0) do_reset();
        cycle(lvl, $urandom_range(0, 39) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_siren.md
ALARM_SIREN -- requirements
Module: alarm_siren

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4, consecutive high samples of sAlarm required to sound.
REQ-002 Parameter BEEP_ON_CYC, default 8, siren-on cycles per beep.
REQ-003 Parameter BEEP_OFF_CYC, default 8, siren-off cycles per beep.
REQ-004 Parameter TIMEOUT_BEEPS, default 16, beeps before automatic mute.
REQ-005 Parameter HOLDOFF_CYC, default 32, minimum muted cycles after ack or timeout.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sAlarm  input  1  raw alarm condition from the detector (lights on, door open, ignition off).
REQ-009 sAck  input  1  driver acknowledge (key/fob), level-sampled.
REQ-010 sSiren  output  1  siren drive, beep pattern.
REQ-011 sMuted  output  1  high while in HOLDOFF.
REQ-012 sEventCnt  output  4  saturating count of SOUND entries.

Function
REQ-013 FSM states SHALL be IDLE, QUAL, SOUND, HOLDOFF; all outputs registered.
REQ-014 IDLE: sSiren=0, sMuted=0; sAlarm=1 sampled -> QUAL with debounce count 1.
REQ-015 QUAL: sAlarm=0 sampled -> IDLE; count reaching DEBOUNCE_CYC consecutive high samples -> SOUND.
REQ-016 Latency: sAlarm high from edge 0 SHALL give sSiren=1 from cycle DEBOUNCE_CYC.
REQ-017 SOUND entry SHALL increment sEventCnt, saturating at 15.
REQ-018 SOUND: sSiren=1 for BEEP_ON_CYC cycles, then 0 for BEEP_OFF_CYC cycles, repeating; beep count increments at end of each ON phase.
REQ-019 SOUND exit priority (highest first): sAck=1 -> HOLDOFF; end of ON phase with beep count = TIMEOUT_BEEPS -> HOLDOFF; sAlarm=0 -> IDLE.
REQ-020 On any SOUND exit, sSiren SHALL be 0 from the next cycle, mid-phase included.
REQ-021 HOLDOFF: sSiren=0, sMuted=1; counts HOLDOFF_CYC cycles; after expiry -> IDLE on first cycle with sAlarm=0 (re-arm requires alarm deassertion).
REQ-022 sAck in IDLE, QUAL or HOLDOFF SHALL be ignored.
REQ-023 Counter widths SHALL be $clog2 of their parameter + 1; no counter wraps.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, sSiren=0, sMuted=0, sEventCnt=0, all counters 0, independent of clk.
REQ-025 Reset mid-SOUND or mid-HOLDOFF SHALL discard beep/holdoff progress; after release, normal debounce restarts.

Structure
REQ-026 Shared package alarm_pkg SHALL hold the state typedef and parameter defaults.
REQ-027 Debounce SHALL be one sub-module, alarm_debounce (sAlarm in, qualified pulse out, clear in).

Verification (defaults)
REQ-028 sAlarm high cycles 0-2, then low -> sSiren never 1, sEventCnt=0.
REQ-029 sAlarm held high from 0 -> sSiren 1 cycles 4-11, 0 cycles 12-19, 1 cycles 20-27; sEventCnt=1.
REQ-030 sAlarm held high, no ack -> last ON cycle 251, sSiren=0 and sMuted=1 from 252, sMuted stays 1 until sAlarm drops (>=284).
REQ-031 sAlarm high, sAck=1 at cycle 6 (same cycle sAlarm drops) -> sSiren=0 from 7, sMuted=1 cycles 7-38, IDLE at 39.
REQ-032 rst_n low mid-ON phase between clk edges -> sSiren, sMuted, sEventCnt 0 before next edge.
REQ-033 17 separate triggers -> sEventCnt=15, no wrap.
